// File: rtl/rf_pkg.sv
// Shared definitions for the register-file ALU sequencer.
// Contents: default widths, 3-bit opcode constants, and the sequencer FSM state encoding.
// Ports: none (package only).
package rf_pkg;

  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_ADDR_WIDTH = 2;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL1  = 3'b101;
  localparam logic [2:0] OP_SHR1  = 3'b110;
  localparam logic [2:0] OP_LOADI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer's EXEC stage.
// Ports: i_a/i_b operands, i_op opcode -> o_y result, o_carry (carry-out, borrow, or shifted-out bit).
// Latency: zero (purely combinational); LOADI is handled outside, so it yields 0 here.
module rf_alu
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [2:0]            i_op,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic                  o_carry
);

  // One extra bit holds carry-out for ADD and borrow for SUB: the zero-extended
  // difference goes negative (MSB set) exactly when a < b unsigned.
  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y     = '0;
    o_carry = 1'b0;
    case (i_op)
      OP_ADD:  begin o_y = w_sum[DATA_WIDTH-1:0];  o_carry = w_sum[DATA_WIDTH];  end
      OP_SUB:  begin o_y = w_diff[DATA_WIDTH-1:0]; o_carry = w_diff[DATA_WIDTH]; end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SHL1: begin o_y = {i_a[DATA_WIDTH-2:0], 1'b0}; o_carry = i_a[DATA_WIDTH-1]; end
      OP_SHR1: begin o_y = {1'b0, i_a[DATA_WIDTH-1:1]}; o_carry = i_a[0];            end
      default: begin o_y = '0; o_carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Sole write master of the 4x16 register file: accepts one reg-to-reg command per handshake,
// reads sources, runs the ALU, and writes back. Ports: i_cmd_* command handshake in,
// o_read_address*/i_read_data* RF read ports, o_write_* RF write port, o_done/o_result/o_carry/o_zero status.
// Latency: write 3 cycles after acceptance (1 for LOADI); o_cmd_ready high only in IDLE, so upstream holds.
module rf_alu_sequencer
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rd,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] i_cmd_rs2,
  input  logic [DATA_WIDTH-1:0] i_cmd_imm,
  output logic [ADDR_WIDTH-1:0] o_read_address1,
  output logic [ADDR_WIDTH-1:0] o_read_address2,
  input  logic [DATA_WIDTH-1:0] i_read_data1,
  input  logic [DATA_WIDTH-1:0] i_read_data2,
  output logic                  o_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_address,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_zero
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_accept;
  logic [2:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_rd;
  logic [ADDR_WIDTH-1:0]   r_rs1;
  logic [ADDR_WIDTH-1:0]   r_rs2;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_carry;
  logic                    r_zero;
  logic [DATA_WIDTH-1:0]   w_alu_y;
  logic                    w_alu_carry;

  rf_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_y     (w_alu_y),
    .o_carry (w_alu_carry)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Ready is gated by reset so it reads 0 during reset even before the first edge settles state.
  always_comb begin
    w_next_state   = r_state;
    o_cmd_ready    = 1'b0;
    o_write_enable = 1'b0;
    o_done         = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = ~i_reset;
        w_accept    = i_cmd_valid & ~i_reset;
        if (w_accept) w_next_state = (i_cmd_op == OP_LOADI) ? ST_WRITE : ST_READ;
      end
      ST_READ:  w_next_state = ST_EXEC;
      ST_EXEC:  w_next_state = ST_WRITE;
      ST_WRITE: begin
        o_write_enable = 1'b1;
        o_done         = 1'b1;
        w_next_state   = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= i_cmd_op;
        r_rd  <= i_cmd_rd;
        r_rs1 <= i_cmd_rs1;
        r_rs2 <= i_cmd_rs2;
        // LOADI skips READ/EXEC, so its flags are committed at acceptance.
        if (i_cmd_op == OP_LOADI) begin
          r_result <= i_cmd_imm;
          r_carry  <= 1'b0;
          r_zero   <= (i_cmd_imm == '0);
        end
      end
      if (r_state == ST_READ) begin
        r_a <= i_read_data1;
        r_b <= i_read_data2;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_y;
        r_carry  <= w_alu_carry;
        r_zero   <= (w_alu_y == '0);
      end
    end
  end

  assign o_read_address1 = r_rs1;
  assign o_read_address2 = r_rs2;
  assign o_write_address = r_rd;
  assign o_write_data    = r_result;
  assign o_result        = r_result;
  assign o_carry         = r_carry;
  assign o_zero          = r_zero;

endmodule
